// File: rtl/proteus_pkg.sv
// Shared definitions for the Proteus stream packer: FSM encoding, clog2 and
// precision normalisation used by the top level and the lane slices.
package proteus_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } pack_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A precision of zero or wider than a word means "keep the whole value".
  function automatic int norm_prec(input int prec, input int width);
    return ((prec == 0) || (prec > width)) ? width : prec;
  endfunction

endpackage

// File: rtl/proteus_packer_lane.sv
// One lane of the packer: reduce a value to P bits, append it to the packing
// register and hand out completed words. PACKER_SATURATE_EN selects saturation.
module proteus_packer_lane
  import proteus_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int PREC_BITS = 5,
  parameter int FILL_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] value,
  input  logic [PREC_BITS-1:0] prec,
  input  logic [FILL_BITS-1:0] fill,
  input  logic                 accept,
  input  logic                 load,
  output logic [BIT_WIDTH-1:0] word
);

  localparam int RW = 2 * BIT_WIDTH;

  logic [BIT_WIDTH-1:0] mask;
  logic [BIT_WIDTH-1:0] kept;
  logic [RW-1:0]        pack_reg;
  logic [RW-1:0]        pack_next;

`ifdef PACKER_SATURATE_EN
  logic [BIT_WIDTH-1:0] sat_hi;
  logic [BIT_WIDTH-1:0] sat_lo;
  logic [BIT_WIDTH-1:0] sat_val;
`endif

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    mask = {BIT_WIDTH{1'b1}} >> (BIT_WIDTH - int'(prec));
`ifdef PACKER_SATURATE_EN
    sat_hi = (BIT_WIDTH'(1) << (prec - 1'b1)) - BIT_WIDTH'(1);
    sat_lo = ~sat_hi;
    if ($signed(value) > $signed(sat_hi))      sat_val = sat_hi;
    else if ($signed(value) < $signed(sat_lo)) sat_val = sat_lo;
    else                                       sat_val = value;
    kept = sat_val & mask;
`else
    kept = value & mask;
`endif
    pack_next = accept ? (pack_reg | (RW'(kept) << fill)) : pack_reg;
  end

  // Bits above the fill level are always zero, so shifting out a word also
  // clears the register at the end of a group.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_reg <= '0;
      word     <= '0;
    end else if (load) begin
      word     <= pack_next[BIT_WIDTH-1:0];
      pack_reg <= pack_next >> BIT_WIDTH;
    end else begin
      pack_reg <= pack_next;
    end
  end

endmodule

// File: rtl/proteus_stream_packer.sv
// Multi-lane packer top: shared fill count, FILL/DRAIN FSM and valid/ready
// handshake around LANES packer slices. Lane reduction honours PACKER_SATURATE_EN.
module proteus_stream_packer
  import proteus_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int LANES     = 16,
  parameter int PREC_BITS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       o_in_ready,
  input  logic [LANES*BIT_WIDTH-1:0] i_data,
  input  logic [PREC_BITS-1:0]       i_prec,
  input  logic                       i_last,
  output logic                       o_valid,
  input  logic                       i_out_ready,
  output logic [LANES*BIT_WIDTH-1:0] o_data,
  output logic                       o_last,
  output logic [PREC_BITS-1:0]       o_bits
);

  localparam int                   FILL_BITS = clog2(2 * BIT_WIDTH);
  localparam logic [FILL_BITS-1:0] W_FILL    = FILL_BITS'(BIT_WIDTH);
  localparam logic [PREC_BITS-1:0] W_PREC    = PREC_BITS'(BIT_WIDTH);

  pack_state_e          state;
  logic [FILL_BITS-1:0] fill;
  logic [FILL_BITS-1:0] fill_next;
  logic [PREC_BITS-1:0] prec;
  logic                 slot_free;
  logic                 accept;
  logic                 load;

  assign prec       = PREC_BITS'(norm_prec(int'(i_prec), BIT_WIDTH));
  assign fill_next  = fill + FILL_BITS'(prec);
  assign slot_free  = !o_valid || i_out_ready;
  assign o_in_ready = (state == ST_FILL) && slot_free;
  assign accept     = i_valid && o_in_ready;

  // The output word register is reloaded whenever a word completes; in DRAIN
  // the lanes present their leftover bits without accepting new input.
  always_comb begin
    load = 1'b0;
    if (state == ST_FILL)
      load = accept && ((fill_next >= W_FILL) || (i_last && (fill_next != '0)));
    else
      load = slot_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FILL;
      fill    <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_bits  <= '0;
    end else begin
      if (o_valid && i_out_ready) o_valid <= 1'b0;
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (i_last && (fill_next > W_FILL)) begin
              o_valid <= 1'b1;
              o_last  <= 1'b0;
              o_bits  <= W_PREC;
              fill    <= fill_next - W_FILL;
              state   <= ST_DRAIN;
            end else if (i_last && (fill_next != '0)) begin
              o_valid <= 1'b1;
              o_last  <= 1'b1;
              o_bits  <= PREC_BITS'(fill_next);
              fill    <= '0;
            end else if (fill_next >= W_FILL) begin
              o_valid <= 1'b1;
              o_last  <= 1'b0;
              o_bits  <= W_PREC;
              fill    <= fill_next - W_FILL;
            end else begin
              fill    <= fill_next;
            end
          end
        end
        ST_DRAIN: begin
          if (slot_free) begin
            o_valid <= 1'b1;
            o_last  <= 1'b1;
            o_bits  <= PREC_BITS'(fill);
            fill    <= '0;
            state   <= ST_FILL;
          end
        end
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    proteus_packer_lane #(
      .BIT_WIDTH (BIT_WIDTH),
      .PREC_BITS (PREC_BITS),
      .FILL_BITS (FILL_BITS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .value  (i_data[k*BIT_WIDTH +: BIT_WIDTH]),
      .prec   (prec),
      .fill   (fill),
      .accept (accept),
      .load   (load),
      .word   (o_data[k*BIT_WIDTH +: BIT_WIDTH])
    );
  end

endmodule

// File: tb/tb_proteus_stream_packer.sv
// Bench for proteus_stream_packer (BIT_WIDTH=16, LANES=2): directed cases plus
// randomized traffic scored against a bit-accumulator reference model.
module tb_proteus_stream_packer;

  localparam int W  = 16;
  localparam int L  = 2;
  localparam int PB = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_valid = 1'b0;
  logic           o_in_ready;
  logic [L*W-1:0] i_data = '0;
  logic [PB-1:0]  i_prec = '0;
  logic           i_last = 1'b0;
  logic           o_valid;
  logic           i_out_ready = 1'b1;
  logic [L*W-1:0] o_data;
  logic           o_last;
  logic [PB-1:0]  o_bits;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  proteus_stream_packer #(
    .BIT_WIDTH (W),
    .LANES     (L),
    .PREC_BITS (PB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_data      (i_data),
    .i_prec      (i_prec),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_bits      (o_bits)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: each lane accumulates its reduced values as a bit string
  // (LSB first); words are cut off whenever enough bits exist or a group ends.
  typedef struct packed {
    logic [L*W-1:0] data;
    logic           last;
    logic [PB-1:0]  bits;
  } word_t;

  word_t       exp_q[$];
  logic [63:0] acc[L];
  int          cnt = 0;

  function automatic logic [63:0] shape(input logic [W-1:0] v, input int p);
    int sv;
    sv = int'($signed(v));
`ifdef PACKER_SATURATE_EN
    if (sv > (1 << (p - 1)) - 1) sv = (1 << (p - 1)) - 1;
    if (sv < -(1 << (p - 1)))    sv = -(1 << (p - 1));
`endif
    return 64'(sv) & ((64'd1 << p) - 64'd1);
  endfunction

  task automatic model_emit(input int nbits, input logic last);
    word_t e;
    for (int k = 0; k < L; k++) begin
      e.data[k*W +: W] = acc[k][W-1:0];
      acc[k] = acc[k] >> W;
    end
    e.last = last;
    e.bits = PB'(nbits);
    exp_q.push_back(e);
  endtask

  task automatic model_push(input logic [L*W-1:0] d, input logic [PB-1:0] p, input logic last);
    int pe;
    pe = ((p == 0) || (int'(p) > W)) ? W : int'(p);
    for (int k = 0; k < L; k++) acc[k] = acc[k] | (shape(d[k*W +: W], pe) << cnt);
    cnt += pe;
    while ((cnt > W) || (!last && (cnt == W))) begin
      model_emit(W, 1'b0);
      cnt -= W;
    end
    if (last && (cnt > 0)) begin
      model_emit(cnt, 1'b1);
      cnt = 0;
    end
  endtask

  logic           prev_stall = 1'b0;
  logic [L*W-1:0] prev_data;
  logic           prev_last;
  logic [PB-1:0]  prev_bits;

  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      exp_q.delete();
      cnt = 0;
      for (int k = 0; k < L; k++) acc[k] = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_data", o_data, prev_data);
        check("hold_last", o_last, prev_last);
        check("hold_bits", o_bits, prev_bits);
      end
      if (o_valid && i_out_ready) begin
        check("word_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("word_data", o_data, e.data);
          check("word_last", o_last, e.last);
          check("word_bits", o_bits, e.bits);
        end
      end
      if (i_valid && o_in_ready) model_push(i_data, i_prec, i_last);
      prev_stall = o_valid && !i_out_ready;
      prev_data  = o_data;
      prev_last  = o_last;
      prev_bits  = o_bits;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_beat(input logic [W-1:0] l0, input logic [W-1:0] l1,
                            input logic [PB-1:0] p, input logic last,
                            input bit rand_ready, output int stalls);
    logic accepted;
    accepted = 1'b0;
    stalls   = 0;
    i_valid  = 1'b1;
    i_data   = {l1, l0};
    i_prec   = p;
    i_last   = last;
    for (int c = 0; c < 200 && !accepted; c++) begin
      if (rand_ready) i_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accepted = o_in_ready;
      if (!accepted) stalls++;
      step();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    check("beat_accepted", accepted, 1);
  endtask

  task automatic wait_out();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    check("out_seen", o_valid, 1);
  endtask

  task automatic group_nibbles();
    int s;
    drive_beat(16'h0001, 16'h000A, 4, 1'b0, 1'b0, s);
    drive_beat(16'h0002, 16'h000B, 4, 1'b0, 1'b0, s);
    drive_beat(16'h0003, 16'h000C, 4, 1'b0, 1'b0, s);
    drive_beat(16'h0004, 16'h000D, 4, 1'b1, 1'b0, s);
    wait_out();
    check("nib_lane0", o_data[W-1:0], 16'h4321);
    check("nib_lane1", o_data[2*W-1:W], 16'hDCBA);
    check("nib_last", o_last, 1);
    check("nib_bits", o_bits, 16);
    step();
  endtask

  initial begin
    int s;
    int total;
    logic [W-1:0] a0, a1, b0, b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_data", o_data, 0);
    check("rst_bits", o_bits, 0);
    check("rst_in_ready", o_in_ready, 1);
    step();
    rst = 1'b0;
    step();

    group_nibbles();

    // A last beat that spans two words forces one DRAIN cycle.
    drive_beat(16'h003F, 16'h0001, 6, 1'b0, 1'b0, s);
    drive_beat(16'h0000, 16'h0002, 6, 1'b0, 1'b0, s);
    drive_beat(16'h0015, 16'h003F, 6, 1'b1, 1'b0, s);
    wait_out();
    check("span_word0", o_data[W-1:0], 16'h503F);
    check("span_last0", o_last, 0);
    check("span_bits0", o_bits, 16);
    check("span_drain_ready", o_in_ready, 0);
    @(negedge clk);
    check("span_valid1", o_valid, 1);
    check("span_word1", o_data[W-1:0], 16'h0001);
    check("span_last1", o_last, 1);
    check("span_bits1", o_bits, 2);
    check("span_ready_back", o_in_ready, 1);
    step();

    // Full-precision beats stream through at one per cycle.
    total = 0;
    for (int i = 0; i < 20; i++) begin
      a0 = W'($urandom);
      a1 = W'($urandom);
      drive_beat(a0, a1, 16, 1'b0, 1'b0, s);
      total += s;
    end
    wait_out();
    check("p16_delay", o_data, {a1, a0});
    check("p16_stalls", total, 0);
    step();

    // Backpressure: output stays put and the input is held off.
    i_out_ready = 1'b0;
    a0 = 16'h1234; a1 = 16'hBEEF;
    b0 = 16'h5A5A; b1 = 16'hC3C3;
    drive_beat(a0, a1, 16, 1'b0, 1'b0, s);
    i_valid = 1'b1;
    i_data  = {b1, b0};
    i_prec  = 16;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", o_valid, 1);
      check("bp_in_ready", o_in_ready, 0);
      check("bp_data", o_data, {a1, a0});
      step();
    end
    i_out_ready = 1'b1;
    drive_beat(b0, b1, 16, 1'b0, 1'b0, s);
    wait_out();
    check("bp_resume", o_data, {b1, b0});
    step();

    drive_beat(16'h0009, 16'hFFF0, 4, 1'b1, 1'b0, s);
    wait_out();
`ifdef PACKER_SATURATE_EN
    check("sat_lane0", o_data[W-1:0], 16'h0007);
    check("sat_lane1", o_data[2*W-1:W], 16'h0008);
`else
    check("sat_lane0", o_data[W-1:0], 16'h0009);
    check("sat_lane1", o_data[2*W-1:W], 16'h0000);
`endif
    check("sat_bits", o_bits, 4);
    step();

    // Reset in the middle of a group discards the partial bits.
    drive_beat(16'h001F, 16'h0011, 5, 1'b0, 1'b0, s);
    drive_beat(16'h0015, 16'h000A, 5, 1'b0, 1'b0, s);
    @(negedge clk);
    check("mid_no_out", o_valid, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_ready", o_in_ready, 1);
    step();
    group_nibbles();

    // Random traffic with random precision, group ends and backpressure.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_out_ready = ($urandom_range(0, 1) != 0);
        step();
      end
      drive_beat(W'($urandom), W'($urandom), PB'($urandom_range(0, 31)),
                 (i == 299) || ($urandom_range(0, 3) == 0), 1'b1, s);
    end
    i_out_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("idle_ready", o_in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
